// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD down-timer.
package bcd_timer_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam digit_t BCD_MAX = 4'd9;

  // Saturate a raw nibble to the largest legal BCD digit.
  function automatic digit_t clamp_digit(input digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_dec_digit.sv
// One BCD digit of the decrement chain: subtract borrow_in, wrap 0 -> 9.
module bcd_dec_digit
  import bcd_timer_pkg::*;
(
  input  digit_t digit,
  input  logic   borrow_in,
  output digit_t next_digit,
  output logic   borrow_out
);

  // Borrow ripples upward only when this digit underflows.
  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        next_digit = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_timer.sv
// Cascadable BCD down-counter/timer with one-shot or periodic expiry.
//
// state | meaning
// IDLE  | count held; waiting for start (or load)
// RUN   | count decrements on each en cycle; expiry at count == 1
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                start,
  input  logic                en,
  input  logic                wrap,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                done,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ONE = W'(1);

  state_t         state, state_next;
  logic [W-1:0]   preset, preset_next;
  logic [W-1:0]   count_next;
  logic           done_next, load_err_next;
  logic [W-1:0]   clamped;
  logic           over_any;
  logic [W-1:0]   dec_value;
  logic [DIGITS:0] borrow;
  logic           is_zero, is_one, dec_strobe;

  assign is_zero    = (count == '0);
  assign is_one     = (count == ONE);
  assign dec_strobe = (state == RUN) && en;
  assign borrow[0]  = dec_strobe;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dec
      bcd_dec_digit u_dec (
        .digit      (count[4*g +: 4]),
        .borrow_in  (borrow[g]),
        .next_digit (dec_value[4*g +: 4]),
        .borrow_out (borrow[g+1])
      );
    end
  endgenerate

  // Clamp each preset digit to 9 and flag any digit that needed it.
  always_comb begin
    clamped  = '0;
    over_any = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      clamped[4*i +: 4] = clamp_digit(load_value[4*i +: 4]);
      if (load_value[4*i +: 4] > BCD_MAX) over_any = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; load always forces IDLE.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start && !is_zero) state_next = RUN;
        RUN:  if (en && is_one && !wrap) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath next values: load, zero-start pulse, decrement, expiry.
  always_comb begin
    count_next    = count;
    preset_next   = preset;
    done_next     = 1'b0;
    load_err_next = load_err;
    if (load) begin
      count_next    = clamped;
      preset_next   = clamped;
      load_err_next = over_any;
    end else if (state == IDLE) begin
      if (start && is_zero) done_next = 1'b1;
    end else if (dec_strobe) begin
      if (is_one) begin
        done_next  = 1'b1;
        count_next = wrap ? preset : '0;
      end else if (!borrow[DIGITS]) begin
        // A top-level borrow would mean underflow past zero; hold instead.
        count_next = dec_value;
      end
    end
  end

  // Registered count, preset and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      preset   <= '0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_next;
      preset   <= preset_next;
      done     <= done_next;
      load_err <= load_err_next;
    end
  end

  assign running = (state == RUN);

endmodule
